// File: rtl/carfield_periph_demux_pkg.sv
// Shared types, slave indices and the peripheral address map for the Carfield
// peripheral register-bus demultiplexer.
package carfield_periph_demux_pkg;

  localparam int unsigned NumPeriphSlaves = 5;
  localparam int unsigned RuleAddrWidth   = 48;
  localparam int unsigned IdxWidth        = 3;

  localparam logic [IdxWidth-1:0] CanIdx      = 3'd0;
  localparam logic [IdxWidth-1:0] TimerIdx    = 3'd1;
  localparam logic [IdxWidth-1:0] AdvTimerIdx = 3'd2;
  localparam logic [IdxWidth-1:0] WdtIdx      = 3'd3;
  localparam logic [IdxWidth-1:0] HypCfgIdx   = 3'd4;

  // carfield_configuration bases, sizes and compile-time enables
  localparam logic [RuleAddrWidth-1:0] CanBase      = 48'h0000_2000_1000;
  localparam logic [RuleAddrWidth-1:0] CanSize      = 48'h0000_0000_1000;
  localparam logic [RuleAddrWidth-1:0] TimerBase    = 48'h0000_2000_4000;
  localparam logic [RuleAddrWidth-1:0] TimerSize    = 48'h0000_0000_1000;
  localparam logic [RuleAddrWidth-1:0] AdvTimerBase = 48'h0000_2000_5000;
  localparam logic [RuleAddrWidth-1:0] AdvTimerSize = 48'h0000_0000_1000;
  localparam logic [RuleAddrWidth-1:0] WdtBase      = 48'h0000_2000_7000;
  localparam logic [RuleAddrWidth-1:0] WdtSize      = 48'h0000_0000_1000;
  localparam logic [RuleAddrWidth-1:0] HypCfgBase   = 48'h0000_2000_9000;
  localparam logic [RuleAddrWidth-1:0] HypCfgSize   = 48'h0000_0000_1000;

  localparam logic CanEnable      = 1'b0;
  localparam logic TimerEnable    = 1'b1;
  localparam logic AdvTimerEnable = 1'b1;
  localparam logic WdtEnable      = 1'b1;
  localparam logic HypCfgEnable   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2,
    RSP  = 2'd3
  } periph_demux_state_e;

  typedef struct packed {
    logic [IdxWidth-1:0]      idx;
    logic [RuleAddrWidth-1:0] start_addr;
    logic [RuleAddrWidth-1:0] end_addr;
    logic                     enable;
  } periph_rule_t;

  // Inclusive start, exclusive end
  localparam periph_rule_t PeriphRules [NumPeriphSlaves] = '{
    '{idx: CanIdx,      start_addr: CanBase,      end_addr: CanBase + CanSize,           enable: CanEnable},
    '{idx: TimerIdx,    start_addr: TimerBase,    end_addr: TimerBase + TimerSize,       enable: TimerEnable},
    '{idx: AdvTimerIdx, start_addr: AdvTimerBase, end_addr: AdvTimerBase + AdvTimerSize, enable: AdvTimerEnable},
    '{idx: WdtIdx,      start_addr: WdtBase,      end_addr: WdtBase + WdtSize,           enable: WdtEnable},
    '{idx: HypCfgIdx,   start_addr: HypCfgBase,   end_addr: HypCfgBase + HypCfgSize,     enable: HypCfgEnable}
  };

endpackage

// File: rtl/carfield_periph_addr_decode.sv
// Combinational address decoder: matches an address against PeriphRules and
// reports the slave index, whether any rule hit, and whether that slave is enabled.
module carfield_periph_addr_decode
  import carfield_periph_demux_pkg::*;
#(
  parameter int unsigned AddrWidth = 48
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 hit_o,
  output logic                 enabled_o
);

  // Compare at 64 bits so nonzero upper address bits can never alias into a rule
  logic [63:0] addr_ext;
  assign addr_ext = 64'(addr_i);

  always_comb begin
    idx_o     = '0;
    hit_o     = 1'b0;
    enabled_o = 1'b0;
    for (int unsigned i = 0; i < NumPeriphSlaves; i++) begin
      if (!hit_o &&
          addr_ext >= 64'(PeriphRules[i].start_addr) &&
          addr_ext <  64'(PeriphRules[i].end_addr)) begin
        hit_o     = 1'b1;
        idx_o     = PeriphRules[i].idx;
        enabled_o = PeriphRules[i].enable;
      end
    end
  end

endmodule

// File: rtl/carfield_periph_regbus_demux.sv
// Register-bus demux from the host crossbar port to the Carfield peripherals.
// Optional slave timeout enabled by defining CARFIELD_PERIPH_TIMEOUT_EN.
module carfield_periph_regbus_demux
  import carfield_periph_demux_pkg::*;
#(
  parameter int unsigned NumSlaves     = 5,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  input  logic                           req_write_i,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic [DataWidth-1:0]           req_wdata_i,
  input  logic [DataWidth/8-1:0]         req_wstrb_i,
  output logic                           rsp_ready_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           rsp_error_o,
  output logic [NumSlaves-1:0]           slv_valid_o,
  output logic                           slv_write_o,
  output logic [AddrWidth-1:0]           slv_addr_o,
  output logic [DataWidth-1:0]           slv_wdata_o,
  output logic [DataWidth/8-1:0]         slv_wstrb_o,
  input  logic [NumSlaves-1:0]           slv_ready_i,
  input  logic [NumSlaves*DataWidth-1:0] slv_rdata_i,
  input  logic [NumSlaves-1:0]           slv_error_i,
  output logic                           timeout_o,
  output logic [7:0]                     timeout_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  if (TimeoutCycles < 2) begin : gen_bad_timeout
    $error("TimeoutCycles must be at least 2");
  end
  if (NumSlaves != NumPeriphSlaves) begin : gen_bad_slaves
    $error("NumSlaves must match the peripheral address map");
  end

  periph_demux_state_e state_q, state_d;

  logic [IdxWidth-1:0]  dec_idx, idx_q;
  logic                 dec_hit, dec_enabled;
  logic                 write_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0] wstrb_q;
  logic [NumSlaves-1:0] slv_valid_q, slv_valid_d;
  logic                 rsp_ready_q, rsp_ready_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 accept;
  logic                 sel_ready, sel_error;
  logic [DataWidth-1:0] sel_rdata;
  logic                 timeout_hit;

  carfield_periph_addr_decode #(
    .AddrWidth (AddrWidth)
  ) i_addr_decode (
    .addr_i    (req_addr_i),
    .idx_o     (dec_idx),
    .hit_o     (dec_hit),
    .enabled_o (dec_enabled)
  );

  assign accept    = (state_q == IDLE) && req_valid_i;
  assign sel_ready = slv_ready_i[idx_q];
  assign sel_error = slv_error_i[idx_q];
  assign sel_rdata = slv_rdata_i[32'(idx_q)*DataWidth +: DataWidth];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; RSP never looks at the request, so a held valid cannot re-issue
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = (dec_hit && dec_enabled) ? FWD : ERR;
      FWD:  if (sel_ready || timeout_hit) state_d = RSP;
      ERR:  state_d = RSP;
      RSP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered master/slave outputs
  always_comb begin
    slv_valid_d = '0;
    rsp_ready_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && dec_hit && dec_enabled) begin
          slv_valid_d = NumSlaves'(1) << dec_idx;
        end
      end
      FWD: begin
        if (sel_ready) begin
          rsp_ready_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : sel_rdata;
          rsp_error_d = sel_error;
        end else if (timeout_hit) begin
          rsp_ready_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          slv_valid_d = slv_valid_q;
        end
      end
      ERR: begin
        rsp_ready_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Request payload capture and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      slv_valid_q <= '0;
      rsp_ready_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= dec_idx;
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
      slv_valid_q <= slv_valid_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

`ifdef CARFIELD_PERIPH_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles);

  logic [CntWidth-1:0] fwd_cnt_q;
  logic                timeout_q;
  logic [7:0]          timeout_cnt_q;

  // A ready on the limit cycle takes priority over the abort
  assign timeout_hit = (state_q == FWD) && !sel_ready &&
                       (fwd_cnt_q == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_cnt_q     <= '0;
      timeout_q     <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      if (state_q != FWD)  fwd_cnt_q <= '0;
      else                 fwd_cnt_q <= fwd_cnt_q + CntWidth'(1);
      if (timeout_hit) begin
        timeout_q <= 1'b1;
        if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
      end
    end
  end

  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_o     = 1'b0;
  assign timeout_cnt_o = 8'd0;
`endif

  assign slv_valid_o = slv_valid_q;
  assign slv_write_o = write_q;
  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_wstrb_o = wstrb_q;
  assign rsp_ready_o = rsp_ready_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;

endmodule

// File: doc/carfield_periph_regbus_demux.md
# carfield_periph_regbus_demux

Register-bus demultiplexer between the host register-bus crossbar port and the Carfield peripheral slaves: CAN, system timer, advanced timer, watchdog, HyperBus config. Decodes each request against the `carfield_configuration` address map, forwards it to one slave and returns that slave's response. Unmapped or compile-disabled regions and unresponsive slaves get an error response. One request in flight at a time.

## Interface
- `NumSlaves`, 5, slave ports: 0 CAN, 1 timer, 2 adv timer, 3 watchdog, 4 HyperBus cfg
- `AddrWidth`, 48, request address width
- `DataWidth`, 32, data width; strobe width is DataWidth/8
- `TimeoutCycles`, 256, max slave wait cycles before abort; must be ≥2
- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `req_valid_i` in 1 / `req_write_i` in 1 / `req_addr_i` in AddrWidth / `req_wdata_i` in DataWidth / `req_wstrb_i` in DataWidth/8: master request, held stable until `rsp_ready_o`
- `rsp_ready_o` out 1 / `rsp_rdata_o` out DataWidth / `rsp_error_o` out 1: master response, valid when `rsp_ready_o`=1
- `slv_valid_o` out NumSlaves / `slv_write_o` out 1 / `slv_addr_o` out AddrWidth / `slv_wdata_o` out DataWidth / `slv_wstrb_o` out DataWidth/8: slave request, payload shared by all slaves, valid one-hot
- `slv_ready_i` in NumSlaves / `slv_rdata_i` in NumSlaves×DataWidth / `slv_error_i` in NumSlaves: slave responses
- `timeout_o` out 1: sticky flag, set on any timeout, cleared only by reset
- `timeout_cnt_o` out 8: saturating count of timeouts

## Operation
- FSM states: IDLE, FWD, ERR, RSP.
- IDLE, `req_valid_i`=1: register the payload and decode the address with inclusive-base, exclusive-end ranges from the package.
  - Hit on an enabled slave: store its index, go to FWD.
  - Miss, or a hit on a disabled slave (CAN when `CanEnable`=0): go to ERR.
- FWD: drive `slv_valid_o[idx]`=1 from the registered payload.
  - On `slv_ready_i[idx]`: capture `slv_rdata_i[idx]` (forced to 0 on writes) and `slv_error_i[idx]`, then go to RSP.
  - Ready on a non-selected slave is ignored.
- ERR: capture rdata=0 and error=1, then go to RSP.
- RSP: drive `rsp_ready_o`=1 for exactly one cycle with the captured data, then go to IDLE.
  - The request is not re-sampled in the RSP cycle, so a held `req_valid_i` cannot cause a double issue.
- Address decode uses the full AddrWidth. Bits above bit 31 that are nonzero give a miss.
- Reset value of every output is 0.
- Reset mid-transaction returns the FSM to IDLE, drops `slv_valid_o`, and discards the response.

## Timing
- Decoded request to slave: `slv_valid_o` rises the cycle after `req_valid_i` is sampled in IDLE.
- Slave ready to master: `rsp_ready_o` is 1 the cycle after `slv_ready_i`. Minimum total latency is 3 cycles (valid→FWD→RSP).
- Error path: `rsp_ready_o` is 1 two cycles after `req_valid_i`.
- All outputs are driven from registers. There is no combinational path from slave inputs to master outputs.
- Back-to-back requests: the next request is sampled in the cycle after RSP, so throughput is at most 1 request per 3 cycles.

## Configuration
- Macro: `CARFIELD_PERIPH_TIMEOUT_EN`.
- Defined:
  - A counter runs in FWD and clears on entry to FWD.
  - If the counter reaches TimeoutCycles-1 without ready, drop `slv_valid_o`, respond with error=1 and rdata=0, set `timeout_o`, and increment `timeout_cnt_o` (saturating at 255).
  - Ready arriving in the same cycle as the limit wins: normal response, no timeout.
- Undefined:
  - No counter; FWD waits indefinitely.
  - `timeout_o` and `timeout_cnt_o` are tied to 0.

## Structure
- Shared package `carfield_periph_demux_pkg`:
  - State enum `periph_demux_state_e`.
  - Slave index localparams.
  - An address rule struct `periph_rule_t` (idx, start, end, enable) plus a `PeriphRules` array built from the `carfield_configuration` bases, sizes and enables.
- One sub-module, `carfield_periph_addr_decode`: purely combinational. It takes an address and returns `idx`, `hit` and `enabled` from the rule array.

## Test plan
- Read at 0x2000_4000; timer answers ready after 4 cycles with 0xCAFE_F00D → only `slv_valid_o[1]` asserted; `rsp_rdata_o`=0xCAFE_F00D, error=0; `rsp_ready_o` 5 cycles after `slv_valid_o` rose.
- Write 0x1234_5678, strobe 0xF, to 0x2000_9004; HyperBus ready the same cycle → `slv_wdata_o` correct; response rdata=0, error=0, latency 3.
- Access 0x2000_1000 with `CanEnable`=0, and 0x2000_6000 (gap) → no `slv_valid_o` bit asserted; error=1 two cycles after request.
- Macro defined: watchdog never ready → error response after 256 FWD cycles, `timeout_o`=1, `timeout_cnt_o`=1. A second request succeeds normally.
- Ready arriving exactly on cycle TimeoutCycles-1 → normal response, `timeout_cnt_o` unchanged.
- `rst_ni` pulsed low while in FWD → all outputs 0 immediately. After release, a new read at 0x2000_7000 completes correctly.
